// File: rtl/layer_sequencer.sv
// Sequences one shared MAC/activation datapath across every neuron of a
// fully-connected layer, buffering each activated result for the next layer.
module layer_sequencer #(
    parameter int unsigned NUM_INPUTS     = 16,
    parameter int unsigned NUM_NEURONS    = 8,
    parameter int unsigned INTEGER_WIDTH  = 8,
    parameter int unsigned FRACTION_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                                                     clock,
    input  logic                                                     reset,
    input  logic                                                     inputs_ready,
    output logic                                                     busy,
    output logic                                                     mac_clear,
    output logic                                                     mac_enable,
    output logic [$clog2(NUM_INPUTS)-1:0]                            input_num,
    output logic [$clog2(NUM_NEURONS)-1:0]                           neuron_num,
    output logic                                                     activate,
    input  logic signed [INTEGER_WIDTH+FRACTION_WIDTH-1:0]           neuron_out,
    input  logic                                                     neuron_out_ready,
    output logic [NUM_NEURONS-1:0][INTEGER_WIDTH+FRACTION_WIDTH-1:0] outputs,
    output logic                                                     outputs_ready,
    input  logic                                                     outputs_taken,
    output logic                                                     timeout_error
);

    localparam int unsigned DATA_W = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int unsigned IN_W   = $clog2(NUM_INPUTS);
    localparam int unsigned NN_W   = $clog2(NUM_NEURONS);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IN_W-1:0]   IN_LAST   = IN_W'(NUM_INPUTS - 1);
    localparam logic [NN_W-1:0]   NN_LAST   = NN_W'(NUM_NEURONS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUMULATE,
        ACTIVATE,
        WAIT_RESULT,
        DONE
    } state_e;

    state_e                                state_q, state_d;
    logic [IN_W-1:0]                       input_num_q, input_num_d;
    logic [NN_W-1:0]                       neuron_num_q, neuron_num_d;
    logic [WAIT_W-1:0]                     wait_q, wait_d;
    logic [NUM_NEURONS-1:0][DATA_W-1:0]    outputs_q, outputs_d;
    logic                                  timeout_q, timeout_d;
    logic                                  neuron_done;

    logic busy_q, mac_clear_q, mac_enable_q, activate_q, outputs_ready_q;

    // Next-state, index and result-buffer logic
    always_comb begin
        state_d      = state_q;
        input_num_d  = '0;
        neuron_num_d = neuron_num_q;
        wait_d       = wait_q;
        outputs_d    = outputs_q;
        timeout_d    = timeout_q;
        neuron_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (inputs_ready) begin
                    state_d      = CLEAR;
                    neuron_num_d = '0;
                    timeout_d    = 1'b0;
                end
            end
            CLEAR: state_d = ACCUMULATE;
            ACCUMULATE: begin
                if (input_num_q == IN_LAST) begin
                    state_d = ACTIVATE;
                end else begin
                    input_num_d = input_num_q + IN_W'(1);
                end
            end
            ACTIVATE: begin
                state_d = WAIT_RESULT;
                wait_d  = '0;
            end
            WAIT_RESULT: begin
                // A result on the timeout cycle still wins over the timeout
                if (neuron_out_ready) begin
                    outputs_d[neuron_num_q] = neuron_out;
                    neuron_done             = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    outputs_d[neuron_num_q] = '0;
                    timeout_d               = 1'b1;
                    neuron_done             = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (neuron_done) begin
                    if (neuron_num_q == NN_LAST) begin
                        state_d = DONE;
                    end else begin
                        neuron_num_d = neuron_num_q + NN_W'(1);
                        state_d      = CLEAR;
                    end
                end
            end
            DONE: begin
                if (outputs_taken) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; strobes are registered decodes of the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            input_num_q     <= '0;
            neuron_num_q    <= '0;
            wait_q          <= '0;
            outputs_q       <= '0;
            timeout_q       <= 1'b0;
            busy_q          <= 1'b0;
            mac_clear_q     <= 1'b0;
            mac_enable_q    <= 1'b0;
            activate_q      <= 1'b0;
            outputs_ready_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            input_num_q     <= input_num_d;
            neuron_num_q    <= neuron_num_d;
            wait_q          <= wait_d;
            outputs_q       <= outputs_d;
            timeout_q       <= timeout_d;
            busy_q          <= (state_d != IDLE);
            mac_clear_q     <= (state_d == CLEAR);
            mac_enable_q    <= (state_d == ACCUMULATE);
            activate_q      <= (state_d == ACTIVATE);
            outputs_ready_q <= (state_d == DONE);
        end
    end

    assign busy          = busy_q;
    assign mac_clear     = mac_clear_q;
    assign mac_enable    = mac_enable_q;
    assign activate      = activate_q;
    assign outputs_ready = outputs_ready_q;
    assign input_num     = input_num_q;
    assign neuron_num    = neuron_num_q;
    assign outputs       = outputs_q;
    assign timeout_error = timeout_q;

endmodule
